clock_div_pulse: RTL and testbench

- Parameterised clock-enable generator. Produces a single-cycle, active-high PULSE once every N cycles of CLK.
- Downstream logic uses PULSE as a synchronous clock enable. No derived clocks are created.
- The module also provides a constant function, MinBitWidth, which sizes the internal counter. Benches call it hierarchically.

---
 rtl/clock_div_pulse.sv | 64 ++++++
 tb/tb_clock_div_pulse.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/clock_div_pulse.sv
// Clock-enable generator: one-cycle PULSE every N cycles of CLK (no derived clocks).
// Latency: PULSE is registered; first high after edge r+N where r is the last reset edge.
// Backpressure: none; free-running, restarted only by RESET.
//
// Ports:
//   CLK   - system clock, all state on the rising edge
//   RESET - synchronous active-high reset, clears counter and PULSE
//   PULSE - registered enable, high for exactly one CLK cycle per period
module clock_div_pulse #(
    parameter integer N = 2
) (
    input  logic CLK,
    input  logic RESET,
    output logic PULSE
);

    // ceil(log2(value)), never less than 1. Kept inside the module so it can
    // be called hierarchically and used in elaboration-time expressions.
    function automatic integer MinBitWidth(input integer value);
        integer result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam integer W = MinBitWidth(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    generate
        if (N < 1) begin : g_bad_n
            $error("clock_div_pulse: N must be >= 1");
        end
    endgenerate

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         pulse_q;
    logic         pulse_d;

    // Explicit wrap at LAST keeps the counter inside 0..N-1 for any N;
    // for N = 2^W the wrap coincides with natural overflow. With N = 1,
    // LAST is 0 so the counter holds at 0 and PULSE stays high.
    always_comb begin
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        pulse_d = (cnt_q == LAST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign PULSE = pulse_q;

endmodule

// File: tb/tb_clock_div_pulse.sv
module tb_clock_div_pulse;

    logic CLK;
    logic rst_a;
    logic rst4;
    logic rst8;
    logic pulse2, pulse5, pulse1, pulse4, pulse8;

    int total = 0;
    int bad   = 0;
    int max5  = 0;

    clock_div_pulse #(.N(2)) dut2 (.CLK(CLK), .RESET(rst_a), .PULSE(pulse2));
    clock_div_pulse #(.N(5)) dut5 (.CLK(CLK), .RESET(rst_a), .PULSE(pulse5));
    clock_div_pulse #(.N(1)) dut1 (.CLK(CLK), .RESET(rst_a), .PULSE(pulse1));
    clock_div_pulse #(.N(4)) dut4 (.CLK(CLK), .RESET(rst4),  .PULSE(pulse4));
    clock_div_pulse #(.N(8)) dut8 (.CLK(CLK), .RESET(rst8),  .PULSE(pulse8));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Track the largest counter value seen in the N=5 instance after reset.
    logic seen_reset5 = 1'b0;
    always @(negedge CLK) begin
        if (rst_a) seen_reset5 = 1'b1;
        if (seen_reset5 && !$isunknown(dut5.cnt_q) && 32'(dut5.cnt_q) > max5)
            max5 = 32'(dut5.cnt_q);
    end

    typedef struct {
        logic rst;
        logic exp2;
        logic exp5;
        logic exp1;
    } vec_t;

    typedef struct {
        int arg;
        int res;
    } mbw_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs[15];
    mbw_t mbw[9];

    initial begin
        int first_hi;
        int npulse;
        int last_hi;
        int gap_bad;

        rst_a = 1'b1;
        rst4  = 1'b1;
        rst8  = 1'b1;

        // MinBitWidth required values
        mbw[0] = '{1, 1};    mbw[1] = '{2, 1};    mbw[2] = '{3, 2};
        mbw[3] = '{4, 2};    mbw[4] = '{5, 3};    mbw[5] = '{8, 3};
        mbw[6] = '{9, 4};    mbw[7] = '{1024, 10}; mbw[8] = '{1025, 11};

        // Per-edge vectors for N=2, N=5, N=1 sharing one reset.
        // k counts non-reset edges after the last reset edge: N=2 high at even k,
        // N=5 high at k multiple of 5, N=1 always high.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1}; // k=1
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // k=2
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1}; // k=3
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // k=4
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1}; // k=5
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // k=6
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1}; // k=7
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // k=8
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1}; // k=9
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1}; // k=10
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1}; // k=11
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0}; // reset forces PULSE low next edge
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1}; // k=1 again

        for (int i = 0; i < 9; i++) begin
            chk($sformatf("mbw(%0d)", mbw[i].arg), 32'(dut2.MinBitWidth(mbw[i].arg)), 32'(mbw[i].res));
        end
        chk("n5_width", 32'(dut5.W), 32'd3);

        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            rst_a = vecs[i].rst;
            step();
            chk($sformatf("n2_v%0d", i), 32'(pulse2), 32'(vecs[i].exp2));
            chk($sformatf("n5_v%0d", i), 32'(pulse5), 32'(vecs[i].exp5));
            chk($sformatf("n1_v%0d", i), 32'(pulse1), 32'(vecs[i].exp1));
        end
        chk("n5_cnt_max", 32'(max5), 32'd4);

        // N=4: reset mid-period when counter reaches 2, phase must restart.
        @(negedge CLK); rst4 = 1'b1;
        step();
        chk("n4_rst_pulse", 32'(pulse4), 32'd0);
        @(negedge CLK); rst4 = 1'b0;
        step();
        step();
        chk("n4_cnt_before", 32'(dut4.cnt_q), 32'd2);
        chk("n4_pulse_before", 32'(pulse4), 32'd0);
        @(negedge CLK); rst4 = 1'b1;
        step();
        chk("n4_mid_rst_pulse", 32'(pulse4), 32'd0);
        chk("n4_mid_rst_cnt", 32'(dut4.cnt_q), 32'd0);
        @(negedge CLK); rst4 = 1'b0;
        first_hi = -1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (pulse4 === 1'b1 && first_hi < 0) first_hi = e;
        end
        chk("n4_first_pulse_edge", 32'(first_hi), 32'd4);

        // N=8: 100 cycles after release, 12 pulses spaced by 8.
        @(negedge CLK); rst8 = 1'b1;
        step();
        chk("n8_rst_pulse", 32'(pulse8), 32'd0);
        @(negedge CLK); rst8 = 1'b0;
        npulse  = 0;
        last_hi = 0;
        gap_bad = 0;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (pulse8 === 1'b1) begin
                npulse++;
                if (e - last_hi != 8) gap_bad++;
                last_hi = e;
            end else if (pulse8 !== 1'b0) begin
                gap_bad++;
            end
        end
        chk("n8_pulse_count", 32'(npulse), 32'd12);
        chk("n8_gap_errors", 32'(gap_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
